// File: rtl/roi_axis_crop.sv
// Region-of-interest cropper for AXI-Stream video: forwards only the pixels inside an
// inclusive rectangle, re-framing them with tuser/tlast through a 2-entry output FIFO.
module roi_axis_crop #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int BIT_D  = 8,
    parameter int CH     = 1,
    parameter int BIT_C  = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [CH*BIT_D-1:0] s_tdata_i,
    input  logic                s_tvalid_i,
    output logic                s_tready_o,
    input  logic                s_tuser_i,
    input  logic                s_tlast_i,
    input  logic [BIT_C-1:0]    xy_0_i,
    input  logic [BIT_C-1:0]    xy_1_i,
    output logic [CH*BIT_D-1:0] m_tdata_o,
    output logic                m_tvalid_o,
    input  logic                m_tready_i,
    output logic                m_tuser_o,
    output logic                m_tlast_o,
    output logic                frame_done_o,
    output logic                roi_err_o
);
    localparam int DW  = CH * BIT_D;
    localparam int CXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CYW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] FRAME    = 2'd1;
    localparam logic [1:0] DISCARD  = 2'd2;

    logic [1:0]     state;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [10:0]    xl, xr;
    logic [9:0]     yt, yb;
    logic [1:0]     count;
    logic [DW-1:0]  head_data, tail_data;
    logic           head_user, head_last, tail_user, tail_last;
    logic           frame_done, roi_err;

    logic [10:0]    x0, x1, nxl, nxr, exl, exr;
    logic [9:0]     y0, y1, nyt, nyb, eyt, eyb;
    logic           accept, sof, roi_ok, active, hit, in_user, in_last, pop, wrap, frame_end;
    logic [CXW-1:0] cur_cx, nxt_cx;
    logic [CYW-1:0] cur_cy, nxt_cy;
    logic [15:0]    px, py;
    logic           unused_bits;

    assign unused_bits  = ^{xy_0_i[BIT_C-1:27], xy_0_i[15:10], xy_1_i[BIT_C-1:27], xy_1_i[15:10]};

    assign s_tready_o   = !arst_i && (count < 2'd2);
    assign m_tvalid_o   = (count != 2'd0);
    assign m_tdata_o    = head_data;
    assign m_tuser_o    = head_user;
    assign m_tlast_o    = head_last;
    assign frame_done_o = frame_done;
    assign roi_err_o    = roi_err;

    // The SOF beat is pixel (0,0) of the new frame, so it is judged against the
    // freshly normalised corners rather than the latched ones.
    always_comb begin
        x0        = xy_0_i[26:16];
        y0        = xy_0_i[9:0];
        x1        = xy_1_i[26:16];
        y1        = xy_1_i[9:0];
        nxl       = (x0 < x1) ? x0 : x1;
        nxr       = (x0 < x1) ? x1 : x0;
        nyt       = (y0 < y1) ? y0 : y1;
        nyb       = (y0 < y1) ? y1 : y0;
        roi_ok    = ({5'd0, nxr} < 16'(WIDTH)) && ({6'd0, nyb} < 16'(HEIGHT));
        accept    = s_tvalid_i && s_tready_o;
        sof       = accept && s_tuser_i;
        exl       = sof ? nxl : xl;
        exr       = sof ? nxr : xr;
        eyt       = sof ? nyt : yt;
        eyb       = sof ? nyb : yb;
        cur_cx    = sof ? '0 : cx;
        cur_cy    = sof ? '0 : cy;
        px        = 16'(cur_cx);
        py        = 16'(cur_cy);
        active    = sof ? roi_ok : (state == FRAME);
        hit       = accept && active && (px >= 16'(exl)) && (px <= 16'(exr))
                    && (py >= 16'(eyt)) && (py <= 16'(eyb));
        in_user   = (px == 16'(exl)) && (py == 16'(eyt));
        in_last   = (px == 16'(exr));
        pop       = m_tvalid_o && m_tready_i;
        wrap      = s_tlast_i || (cur_cx == CXW'(WIDTH - 1));
        nxt_cx    = wrap ? '0 : cur_cx + CXW'(1);
        nxt_cy    = wrap ? cur_cy + CYW'(1) : cur_cy;
        frame_end = (cur_cx == CXW'(WIDTH - 1)) && (cur_cy == CYW'(HEIGHT - 1));
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state      <= WAIT_SOF;
            cx         <= '0;
            cy         <= '0;
            count      <= 2'd0;
            head_data  <= '0;
            head_user  <= 1'b0;
            head_last  <= 1'b0;
            frame_done <= 1'b0;
            roi_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sof) begin
                roi_err <= !roi_ok;
                state   <= roi_ok ? FRAME : DISCARD;
            end
            if (accept && (sof || state != WAIT_SOF)) begin
                if (frame_end) begin
                    state      <= WAIT_SOF;
                    frame_done <= 1'b1;
                    cx         <= '0;
                    cy         <= '0;
                end else begin
                    cx <= nxt_cx;
                    cy <= nxt_cy;
                end
            end
            // Head register drives m_* directly; it only changes when empty or popped.
            case (count)
                2'd0: if (hit) begin
                    {head_data, head_user, head_last} <= {s_tdata_i, in_user, in_last};
                    count <= 2'd1;
                end
                2'd1: if (hit && pop) begin
                    {head_data, head_user, head_last} <= {s_tdata_i, in_user, in_last};
                end else if (hit) begin
                    count <= 2'd2;
                end else if (pop) begin
                    count <= 2'd0;
                end
                default: if (pop) begin
                    {head_data, head_user, head_last} <= {tail_data, tail_user, tail_last};
                    count <= 2'd1;
                end
            endcase
        end
    end

    // NOTE: corner and tail registers carry no reset; they are only read after being
    // written under SOF or a count==1 push, so their power-up value is never observed.
    always_ff @(posedge clk_i) begin
        if (sof) begin
            xl <= nxl;
            xr <= nxr;
            yt <= nyt;
            yb <= nyb;
        end
        if (count == 2'd1 && hit && !pop) begin
            {tail_data, tail_user, tail_last} <= {s_tdata_i, in_user, in_last};
        end
    end
endmodule

// File: tb/tb_roi_axis_crop.sv
// Self-checking bench for roi_axis_crop: table-driven frames plus hand-written abort
// and reset sequences, with a positional reference model feeding a scoreboard queue.
module tb_roi_axis_crop;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          arst_i;
    logic [DW-1:0] s_tdata_i;
    logic          s_tvalid_i, s_tready_o, s_tuser_i, s_tlast_i;
    logic [31:0]   xy_0_i, xy_1_i;
    logic [DW-1:0] m_tdata_o;
    logic          m_tvalid_o, m_tready_i, m_tuser_o, m_tlast_o;
    logic          frame_done_o, roi_err_o;

    always #5 clk = ~clk;

    roi_axis_crop #(.WIDTH(W), .HEIGHT(H), .BIT_D(8), .CH(3), .BIT_C(32)) dut (
        .clk_i(clk), .arst_i(arst_i),
        .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
        .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i),
        .xy_0_i(xy_0_i), .xy_1_i(xy_1_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
        .frame_done_o(frame_done_o), .roi_err_o(roi_err_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    typedef struct {
        int x0, y0, x1, y1;
        int ready_pct, gap_pct;
        int exp_beats;
        bit exp_err;
    } vec_t;

    beat_t q[$];
    beat_t exp_b, held;
    vec_t  vecs[8];
    int    n_cmp = 0, n_bad = 0;
    int    ready_pct = 100, gap_pct = 0;
    int    n_out = 0, done_cnt = 0, fid = 0;
    int    ms = 0, mxl, mxr, myt, myb, mx, my;
    bit    lu, ll, stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_xy(input int x, input int y);
        logic [31:0] v;
        v        = '0;
        v[26:16] = 11'(x);
        v[9:0]   = 10'(y);
        return v;
    endfunction

    // Reference model: tracks the raster position of every accepted beat.
    task automatic model_accept();
        int x0, y0, x1, y1;
        beat_t b;
        if (s_tuser_i) begin
            x0  = int'(xy_0_i[26:16]);
            y0  = int'(xy_0_i[9:0]);
            x1  = int'(xy_1_i[26:16]);
            y1  = int'(xy_1_i[9:0]);
            mxl = (x0 < x1) ? x0 : x1;
            mxr = (x0 < x1) ? x1 : x0;
            myt = (y0 < y1) ? y0 : y1;
            myb = (y0 < y1) ? y1 : y0;
            ms  = (mxr < W && myb < H) ? 1 : 2;
            mx  = 0;
            my  = 0;
        end
        if (ms == 0) return;
        if (ms == 1 && mx >= mxl && mx <= mxr && my >= myt && my <= myb) begin
            b = {s_tdata_i, 1'(mx == mxl && my == myt), 1'(mx == mxr)};
            q.push_back(b);
        end
        if (mx == W - 1 && my == H - 1) ms = 0;
        else if (s_tlast_i || mx == W - 1) begin
            mx = 0;
            my++;
        end else mx++;
    endtask

    always @(posedge clk) begin
        #2;
        m_tready_i = ($urandom_range(0, 99) < ready_pct);
    end

    // Monitor: samples mid-cycle, so inputs and outputs are those seen by the next edge.
    always @(negedge clk) begin
        if (arst_i) begin
            q.delete();
            ms    = 0;
            stall = 0;
        end else begin
            if (stall)
                check("stall_hold", {5'd0, m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o},
                      {5'd0, 1'b1, held});
            stall = m_tvalid_o && !m_tready_i;
            held  = {m_tdata_o, m_tuser_o, m_tlast_o};
            if (m_tvalid_o && m_tready_i) begin
                n_out++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_beat: got %0h expected no beat", m_tdata_o);
                end else begin
                    exp_b = q.pop_front();
                    check("beat", {6'd0, m_tdata_o, m_tuser_o, m_tlast_o}, {6'd0, exp_b});
                    lu = m_tuser_o;
                    ll = m_tlast_o;
                end
            end
            if (frame_done_o) done_cnt++;
            if (s_tvalid_i && s_tready_o) model_accept();
        end
    end

    task automatic send_range(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            int x, y, t;
            bit ok;
            x = i % W;
            y = i / W;
            while ($urandom_range(0, 99) < gap_pct) begin
                s_tvalid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata_i  = {8'(fid), 8'(y), 8'(x)};
            s_tuser_i  = (i == 0);
            s_tlast_i  = (x == W - 1);
            s_tvalid_i = 1'b1;
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 500) begin
                @(negedge clk);
                ok = s_tready_o;
                @(posedge clk);
                #1;
                t++;
            end
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got no s_tready in 500 cycles, expected acceptance");
            end
        end
        s_tvalid_i = 1'b0;
        s_tuser_i  = 1'b0;
        s_tlast_i  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k         = 0;
        ready_pct = 100;
        repeat (3) @(negedge clk);
        while ((q.size() != 0 || m_tvalid_o) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_i     = 1'b1;
        s_tdata_i  = '0;
        s_tvalid_i = 1'b0;
        s_tuser_i  = 1'b0;
        s_tlast_i  = 1'b0;
        xy_0_i     = '0;
        xy_1_i     = '0;
        m_tready_i = 1'b1;

        vecs[0] = '{2, 1, 4, 3, 100,  0,  9, 1'b0};
        vecs[1] = '{4, 3, 2, 1, 100,  0,  9, 1'b0};
        vecs[2] = '{2, 1, 4, 3,  50, 50,  9, 1'b0};
        vecs[3] = '{0, 0, 7, 5,  50, 30, 48, 1'b0};
        vecs[4] = '{3, 0, 1, 5,  70, 20, 18, 1'b0};
        vecs[5] = '{1, 1, 8, 2, 100,  0,  0, 1'b1};
        vecs[6] = '{1, 1, 1, 1,  60, 20,  1, 1'b0};
        vecs[7] = '{7, 5, 7, 5, 100,  0,  1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_tvalid_o, 0);
        check("rst_tready", s_tready_o, 0);
        check("rst_tdata", m_tdata_o, 0);
        check("rst_flags", {m_tuser_o, m_tlast_o, frame_done_o, roi_err_o}, 0);
        @(posedge clk);
        #1;
        arst_i = 1'b0;
        @(negedge clk);
        check("ready_after_rst", s_tready_o, 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            fid++;
            xy_0_i    = mk_xy(vecs[v].x0, vecs[v].y0);
            xy_1_i    = mk_xy(vecs[v].x1, vecs[v].y1);
            ready_pct = vecs[v].ready_pct;
            gap_pct   = vecs[v].gap_pct;
            n_out     = 0;
            done_cnt  = 0;
            send_range(0, W * H - 1);
            gap_pct = 0;
            drain();
            check($sformatf("v%0d_beats", v), n_out, vecs[v].exp_beats);
            check($sformatf("v%0d_leftover", v), q.size(), 0);
            check($sformatf("v%0d_roi_err", v), roi_err_o, {31'd0, vecs[v].exp_err});
            if (!vecs[v].exp_err) check($sformatf("v%0d_done", v), done_cnt, 1);
            if (vecs[v].exp_beats == 1) check($sformatf("v%0d_flags", v), {lu, ll}, 2'b11);
        end

        // Abort: SOF lands on old-frame position (5,2) with new corners (0,0)-(1,0).
        fid++;
        n_out    = 0;
        done_cnt = 0;
        xy_0_i   = mk_xy(2, 1);
        xy_1_i   = mk_xy(4, 3);
        send_range(0, 2 * W + 4);
        fid++;
        xy_0_i = mk_xy(0, 0);
        xy_1_i = mk_xy(1, 0);
        send_range(0, W * H - 1);
        drain();
        check("abort_beats", n_out, 8);
        check("abort_done", done_cnt, 1);

        // Reset with two beats buffered and the sink stalled.
        fid++;
        ready_pct = 0;
        xy_0_i    = mk_xy(0, 0);
        xy_1_i    = mk_xy(7, 5);
        @(posedge clk);
        #1;
        send_range(0, 1);
        @(negedge clk);
        check("two_buffered", {s_tready_o, m_tvalid_o}, 2'b01);
        @(posedge clk);
        #1;
        arst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tvalid", m_tvalid_o, 0);
        check("rst_mid_tready", s_tready_o, 0);
        @(posedge clk);
        #1;
        arst_i = 1'b0;
        @(negedge clk);
        check("rst_count_clear", s_tready_o, 1);
        ready_pct = 100;
        @(posedge clk);
        #1;
        send_range(5, 9);
        fid++;
        n_out    = 0;
        done_cnt = 0;
        xy_0_i   = mk_xy(0, 0);
        xy_1_i   = mk_xy(0, 0);
        send_range(0, 0);
        @(negedge clk);
        check("latency", {m_tvalid_o, m_tuser_o, m_tlast_o}, 3'b111);
        @(posedge clk);
        #1;
        xy_1_i = mk_xy(7, 5);
        send_range(1, W * H - 1);
        drain();
        check("post_rst_beats", n_out, 1);
        check("post_rst_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/roi_axis_crop.md
# roi_axis_crop

Parametrised region-of-interest cropper for AXI-Stream video, successor to the single-channel ROI block in the pixel pipeline. It accepts a raster frame with full `tready` backpressure, start-of-frame (`tuser`) and end-of-line (`tlast`) framing, and multi-channel pixels. It forwards only the pixels inside an inclusive rectangle given by two corner coordinates, which may be in any order. It sits between the capture front end and downstream processing blocks, and emits a well-formed AXI-Stream video sub-frame.

## Interface
- `WIDTH`, 800: frame width in pixels.
- `HEIGHT`, 600: frame height in lines.
- `BIT_D`, 8: bits per channel.
- `CH`, 1: channels per pixel beat.
- `BIT_C`, 32: coordinate register width.
- `clk_i`  in  1: single clock; all logic is on the rising edge.
- `arst_i`  in  1: reset, synchronous, active-high.
- `s_tdata_i`  in  CH*BIT_D: input pixel.
- `s_tvalid_i`  in  1: input valid.
- `s_tready_o`  out  1: input ready.
- `s_tuser_i`  in  1: start of frame; set on pixel (0,0).
- `s_tlast_i`  in  1: end of input line.
- `xy_0_i`  in  BIT_C: corner A; x in [26:16], y in [9:0].
- `xy_1_i`  in  BIT_C: corner B; same layout as corner A.
- `m_tdata_o`  out  CH*BIT_D: output pixel.
- `m_tvalid_o`  out  1: output valid.
- `m_tready_i`  in  1: output ready.
- `m_tuser_o`  out  1: first pixel of the ROI.
- `m_tlast_o`  out  1: last pixel of an ROI row.
- `frame_done_o`  out  1: one-cycle pulse when the last input pixel of a frame is accepted.
- `roi_err_o`  out  1: sticky flag for an invalid ROI; cleared at the next accepted SOF with a valid ROI.

## Operation
- An input beat is accepted when `s_tvalid_i && s_tready_o`.
  - Only accepted beats advance the counters.
- State machine `WAIT_SOF` → `FRAME`.
  - In `WAIT_SOF`, beats without `s_tuser_i` are accepted and dropped.
  - An accepted beat with `s_tuser_i` does the following: latch the corners, normalise them, set the pixel position to (0,0), and enter `FRAME` (or `DISCARD` if the ROI is invalid; see below).
- Corner normalisation:
  - xl = min(x0,x1), xr = max(x0,x1).
  - yt = min(y0,y1), yb = max(y0,y1).
  - Rectangle is inclusive; a single pixel is legal when x0==x1 and y0==y1.
- Validity: xr < WIDTH and yb < HEIGHT.
  - If invalid: set `roi_err_o`, enter the `DISCARD` state, consume the rest of the frame with no output, then return to `WAIT_SOF` at the frame end.
- Counters: cx is $clog2(WIDTH) bits, cy is $clog2(HEIGHT) bits.
  - An accepted beat with `s_tlast_i`, or with cx==WIDTH-1, wraps cx to 0 and increments cy; whichever comes first wins.
- Frame end: the accepted beat at (WIDTH-1, HEIGHT-1) does the following: pulse `frame_done_o`, go to `WAIT_SOF`.
- An SOF accepted mid-frame (`FRAME` or `DISCARD`) aborts the current frame:
  - no `frame_done_o`;
  - corners are re-latched;
  - the beat is treated as (0,0) of the new frame.
- Forwarding rule: a beat with xl≤cx≤xr and yt≤cy≤yb is pushed into the output FIFO with its sideband bits:
  - `m_tuser_o` = (cx==xl && cy==yt);
  - `m_tlast_o` = (cx==xr).
- Beats outside the rectangle are accepted and dropped.
- Output FIFO: 2 entries, registered.
  - `s_tready_o` = !`arst_i` && (count<2).
  - Input readiness does not depend on whether the beat will be forwarded.
- Corner inputs are sampled only at SOF; changing them mid-frame has no effect.

## Timing
- Reset (synchronous, one edge): the following all go to 0:
  - `m_tvalid_o`, `m_tdata_o`, `m_tuser_o`, `m_tlast_o`;
  - `frame_done_o`, `roi_err_o`;
  - FIFO count, cx, cy.
- After reset, state is `WAIT_SOF`. `s_tready_o` is 0 while `arst_i` is high.
- Reset mid-frame discards buffered beats; the next frame must start with an SOF.
- Latency: a forwarded beat accepted at edge N is visible on `m_*` after edge N (first cycle valid is N+1) when the FIFO is empty.
- Throughput: 1 beat/cycle with `m_tready_i` held high.
- With `m_tready_i` low, at most 2 beats are buffered, then `s_tready_o` drops.
- `m_*` are held stable while `m_tvalid_o && !m_tready_i`.
- A simultaneous push and pop with count==2 is impossible (ready is low). With count==1, a simultaneous push and pop keeps count at 1.
- `frame_done_o` is asserted in the cycle after the final beat is accepted, for one cycle.
- `roi_err_o` updates in the cycle after the SOF beat is accepted.

## Test plan
- WIDTH=8, HEIGHT=6, CH=3, xy_0=(2,1), xy_1=(4,3), full-rate frame:
  - 9 beats out, in raster order (2..4,1..3);
  - `m_tuser_o` only on (2,1);
  - `m_tlast_o` on x=4 for rows 1, 2, 3;
  - `frame_done_o` pulses once.
- Swapped corners xy_0=(4,3), xy_1=(2,1): output identical to the previous test.
- Random `m_tready_i` (50%) and random `s_tvalid_i` gaps: output sequence matches the reference model, nothing is lost or duplicated, data is stable under stall.
- xy_1=(8,2) with WIDTH=8:
  - `roi_err_o`=1, no output beats;
  - the next frame with (1,1)-(1,1) gives exactly one beat with tuser=tlast=1 and clears `roi_err_o`.
- SOF injected at (5,2) mid-frame with new corners (0,0)-(1,0):
  - no `frame_done_o` for the aborted frame;
  - the next 2 accepted beats are output with tuser on the first beat and tlast on the second.
- Reset asserted with 2 beats buffered and `m_tready_i`=0: the next cycle has `m_tvalid_o`=0 and count=0; pre-SOF beats after release are dropped.
